password_set_ctrl: RTL and testbench
====================================

Name: password_set_ctrl

Overview:
- Parametrised successor to the fixed 4-digit password setter.
- Collects keypad digits, one per `digit_valid` strobe, and verifies the current password before accepting a change.
- The new password must be entered twice; it is committed to the stored password register only if both entries match.
- Sits between the keypad decoder and the lock comparator, which reads `password`. Adds inactivity timeout, digit range check, cancel, and lockout after repeated failures.

Parameters:
- DIGIT_W, 4, bits per keypad digit.
- NUM_DIGITS, 4, digits per password; PW_W = DIGIT_W*NUM_DIGITS.
- MAX_DIGIT, 9, largest legal digit value; larger values are rejected.
- RESET_PASSWORD, 0, value loaded into `password` on reset (PW_W bits).
- TIMEOUT_CYCLES, 1000, idle cycles between digits before abort.
- MAX_FAILS, 3, consecutive old-password mismatches that trigger lockout.
- LOCK_CYCLES, 5000, lockout duration in clocks.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- set_req  in  1  1-cycle pulse that starts a password change.
- cancel  in  1  abort the current sequence.
- digit  in  DIGIT_W  keypad digit value.
- digit_valid  in  1  `digit` is valid this cycle.
- password  out  PW_W  stored password.
- busy  out  1  a sequence is in progress.
- done  out  1  1-cycle pulse: new password committed.
- err  out  1  1-cycle pulse: sequence aborted.
- err_code  out  3  reason for `err`; holds its value until the next `err`.
- locked  out  1  lockout active.
- digit_cnt  out  $clog2(NUM_DIGITS+1)  digits entered in the current phase.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. Every state element changes only on the `clk` rising edge.
- Reset values: `password`=RESET_PASSWORD; `busy`, `done`, `err`, `locked` all 0; `err_code`=0; `digit_cnt`=0; fail count, timers and buffers 0; state IDLE.
- Reset mid-sequence: the sequence is discarded and any partially entered password is lost.
- Packing: the first digit lands in the MS digit slot. Digits 1,2,3,4 with DIGIT_W=4 give 16'h1234. Each accepted digit is shifted into the buffer: buf <= {buf[PW_W-DIGIT_W-1:0], digit}.
- States:
  - IDLE: `set_req` and not `locked` -> VERIFY, `busy`=1. `set_req` while `locked` -> `err` pulse, code LOCKED; stay in IDLE.
  - VERIFY, ENTER, CONFIRM: each accepted digit increments `digit_cnt`. On the NUM_DIGITS-th digit the next state is the matching CHECK state, and `digit_cnt` clears on entry to CHECK.
  - CHK_V (one cycle): buffer == `password` -> ENTER and fail count cleared. Otherwise -> IDLE, `err`, code OLD_MISMATCH, fail count +1.
  - CHK_V lockout: if the fail count reaches MAX_FAILS, `locked`=1 for exactly LOCK_CYCLES clocks, then `locked`=0 and the fail count clears.
  - CHK_E (one cycle): copy buffer to the new-password hold register -> CONFIRM.
  - CHK_C (one cycle): buffer == hold -> commit `password`, `done` pulse, -> IDLE. Otherwise -> IDLE, `err`, code CONFIRM_MISMATCH.
- Latency: last confirm digit accepted at edge k. `done` and the new `password` are visible after edge k+1. `busy` falls at edge k+1.
- Error codes: 0 NONE, 1 OLD_MISMATCH, 2 CONFIRM_MISMATCH, 3 TIMEOUT, 4 BAD_DIGIT, 5 LOCKED, 6 CANCELLED.
- Bad digit: `digit` > MAX_DIGIT with `digit_valid` in an entry state -> IDLE, `err`, code BAD_DIGIT. Does not count as a fail.
- Timeout:
  - The counter runs in VERIFY, ENTER and CONFIRM, and resets on each accepted digit and on phase entry.
  - Reaching TIMEOUT_CYCLES -> IDLE, `err`, code TIMEOUT.
- Priority in any one cycle: rst > cancel > timeout > digit_valid.
- Cancel: `cancel` in a busy state -> IDLE, `err`, code CANCELLED. `cancel` in IDLE is ignored.
- Ignored inputs: `set_req` while `busy` is ignored. `digit_valid` in IDLE or in a CHK state is ignored.
- Password stability: `password` changes only on a commit or on reset. Aborts and lockout never alter it.

Decomposition:
- Shared package `locker_pkg`: state enum, err_code constants, and a helper for the PW_W computation.
- Sub-module `digit_collector`:
  - Holds the shift buffer, `digit_cnt`, range check and inactivity timer.
  - Outputs `full`, `bad`, `timeout`.
  - Its `clear` input is driven by the FSM on every phase entry.

Test Plan:
- Default params, reset:
  - Stimulus: set_req; digits 0,0,0,0; digits 1,2,3,4; digits 1,2,3,4.
  - Response: `done` 2 cycles after the last `digit_valid`; `password`=16'h1234; `err` never asserted.
- Wrong old password:
  - Stimulus: old password 16'h1234; set_req; digits 9,9,9,9.
  - Response: `err`, code 1; `password` unchanged.
- Lockout:
  - Stimulus: the wrong-old sequence 3 times, then set_req.
  - Response: `locked`=1; set_req gives `err` code 5; `locked` falls after exactly 5000 clocks.
- Confirm mismatch:
  - Stimulus: correct old password; new 5,6,7,8; confirm 5,6,7,9.
  - Response: `err`, code 2; `password` unchanged.
- Timeout with TIMEOUT_CYCLES=10:
  - Stimulus: set_req; two digits; then idle.
  - Response: `err` code 3 on the 10th idle cycle. In a separate run with `cancel` and `digit_valid` in the same cycle: code 6.
- Digit range, then scaled build:
  - Stimulus: digit 4'hC mid-entry.
  - Response: `err` code 4.
  - Stimulus: rebuild with NUM_DIGITS=6, DIGIT_W=4, run a full change, and pulse rst mid-CONFIRM.
  - Response: full change commits a 24-bit value; rst mid-CONFIRM gives `password`=RESET_PASSWORD and `busy`=0.

Source files
------------

// File: rtl/locker_pkg.sv
// Shared types and helpers for the password-change controller.
// Holds the FSM state encoding, err_code values and the password width helper.
package locker_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VERIFY,
    S_CHK_V,
    S_ENTER,
    S_CHK_E,
    S_CONFIRM,
    S_CHK_C
  } state_t;

  localparam logic [2:0] ERR_NONE             = 3'd0;
  localparam logic [2:0] ERR_OLD_MISMATCH     = 3'd1;
  localparam logic [2:0] ERR_CONFIRM_MISMATCH = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT          = 3'd3;
  localparam logic [2:0] ERR_BAD_DIGIT        = 3'd4;
  localparam logic [2:0] ERR_LOCKED           = 3'd5;
  localparam logic [2:0] ERR_CANCELLED        = 3'd6;

  function automatic int unsigned pw_width(input int unsigned dw, input int unsigned nd);
    return dw * nd;
  endfunction

endpackage

// File: rtl/digit_collector.sv
// Keypad digit shift buffer with per-phase digit count, range check and inactivity timer.
// full/bad/timeout are same-cycle flags so the FSM can act on the accepting edge.
module digit_collector import locker_pkg::*; #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned MAX_DIGIT      = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  localparam int unsigned PW_W          = pw_width(DIGIT_W, NUM_DIGITS),
  localparam int unsigned CNT_W         = $clog2(NUM_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               active,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_valid,
  output logic [PW_W-1:0]    buffer,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic               full,
  output logic               bad,
  output logic               timeout
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] idle_cnt;
  logic             accept;

  assign bad     = active && digit_valid && (digit > DIGIT_W'(MAX_DIGIT));
  assign accept  = active && digit_valid && !bad;
  assign full    = accept && (digit_cnt == CNT_W'(NUM_DIGITS - 1));
  assign timeout = active && (idle_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

  // First digit ends up in the most significant slot after NUM_DIGITS shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer    <= '0;
      digit_cnt <= '0;
      idle_cnt  <= '0;
    end else if (clear) begin
      buffer    <= '0;
      digit_cnt <= '0;
      idle_cnt  <= '0;
    end else if (accept) begin
      buffer    <= PW_W'({buffer, digit});
      digit_cnt <= full ? '0 : digit_cnt + CNT_W'(1);
      idle_cnt  <= '0;
    end else if (active) begin
      idle_cnt  <= idle_cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/password_set_ctrl.sv
// Password change controller: verify old, enter new twice, commit on match.
// Adds cancel, inactivity timeout, digit range check and lockout after repeated failures.
module password_set_ctrl import locker_pkg::*; #(
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned NUM_DIGITS     = 4,
  localparam int unsigned PW_W          = pw_width(DIGIT_W, NUM_DIGITS),
  localparam int unsigned CNT_W         = $clog2(NUM_DIGITS + 1),
  parameter logic [PW_W-1:0] RESET_PASSWORD = '0,
  parameter int unsigned MAX_DIGIT      = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCK_CYCLES    = 5000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_req,
  input  logic               cancel,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_valid,
  output logic [PW_W-1:0]    password,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_code,
  output logic               locked,
  output logic [CNT_W-1:0]   digit_cnt
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  state_t              state, state_d;
  logic [PW_W-1:0]     password_d, hold, hold_d, buffer;
  logic [FAIL_W-1:0]   fail_cnt, fail_d;
  logic [LOCK_W-1:0]   lock_cnt, lock_cnt_d;
  logic                locked_d, done_d, err_d;
  logic [2:0]          err_code_d;
  logic                clear, active, full, bad, timeout;

  assign active = (state == S_VERIFY) || (state == S_ENTER) || (state == S_CONFIRM);
  // Entering a CHK state must keep the buffer that the last digit just completed.
  assign clear  = (state_d != state) &&
                  !((state_d == S_CHK_V) || (state_d == S_CHK_E) || (state_d == S_CHK_C));

  digit_collector #(
    .DIGIT_W       (DIGIT_W),
    .NUM_DIGITS    (NUM_DIGITS),
    .MAX_DIGIT     (MAX_DIGIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_collector (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .active     (active),
    .digit      (digit),
    .digit_valid(digit_valid),
    .buffer     (buffer),
    .digit_cnt  (digit_cnt),
    .full       (full),
    .bad        (bad),
    .timeout    (timeout)
  );

  always_comb begin
    state_d    = state;
    password_d = password;
    hold_d     = hold;
    fail_d     = fail_cnt;
    locked_d   = locked;
    lock_cnt_d = lock_cnt;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code;

    // Lockout runs independently of the sequence FSM, which sits in IDLE meanwhile.
    if (locked) begin
      if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
        locked_d   = 1'b0;
        lock_cnt_d = '0;
        fail_d     = '0;
      end else begin
        lock_cnt_d = lock_cnt + LOCK_W'(1);
      end
    end

    if (state == S_IDLE) begin
      if (set_req) begin
        if (locked) begin
          err_d      = 1'b1;
          err_code_d = ERR_LOCKED;
        end else begin
          state_d = S_VERIFY;
        end
      end
    end else if (cancel) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_CANCELLED;
    end else begin
      case (state)
        S_VERIFY, S_ENTER, S_CONFIRM: begin
          if (timeout) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else if (bad) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_BAD_DIGIT;
          end else if (full) begin
            state_d = (state == S_VERIFY) ? S_CHK_V :
                      (state == S_ENTER)  ? S_CHK_E : S_CHK_C;
          end
        end
        S_CHK_V: begin
          if (buffer == password) begin
            state_d = S_ENTER;
            fail_d  = '0;
          end else begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_OLD_MISMATCH;
            fail_d     = fail_cnt + FAIL_W'(1);
            if ((fail_cnt + FAIL_W'(1)) == FAIL_W'(MAX_FAILS)) begin
              locked_d   = 1'b1;
              lock_cnt_d = '0;
            end
          end
        end
        S_CHK_E: begin
          hold_d  = buffer;
          state_d = S_CONFIRM;
        end
        S_CHK_C: begin
          state_d = S_IDLE;
          if (buffer == hold) begin
            password_d = buffer;
            done_d     = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CONFIRM_MISMATCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      password <= RESET_PASSWORD;
      hold     <= '0;
      fail_cnt <= '0;
      locked   <= 1'b0;
      lock_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_d;
      password <= password_d;
      hold     <= hold_d;
      fail_cnt <= fail_d;
      locked   <= locked_d;
      lock_cnt <= lock_cnt_d;
      busy     <= (state_d != S_IDLE);
      done     <= done_d;
      err      <= err_d;
      err_code <= err_code_d;
    end
  end

endmodule

// File: tb/tb_password_set_ctrl.sv
// Scoreboard bench for password_set_ctrl: a default 4-digit build and a 6-digit build
// with short timeout share the same stimulus; the monitor checks the selected one.
module tb_password_set_ctrl;

  typedef struct packed {
    logic        is_err;
    logic [2:0]  code;
    logic [23:0] pw;
    logic [31:0] due;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, set_req, cancel, digit_valid;
  logic [3:0]  digit;

  logic [15:0] password_a;
  logic        busy_a, done_a, err_a, locked_a;
  logic [2:0]  err_code_a, digit_cnt_a;
  logic [23:0] password_b;
  logic        busy_b, done_b, err_b, locked_b;
  logic [2:0]  err_code_b, digit_cnt_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic mon_sel = 1'b0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  password_set_ctrl u_dut_a (
    .clk(clk), .rst(rst), .set_req(set_req), .cancel(cancel),
    .digit(digit), .digit_valid(digit_valid),
    .password(password_a), .busy(busy_a), .done(done_a), .err(err_a),
    .err_code(err_code_a), .locked(locked_a), .digit_cnt(digit_cnt_a)
  );

  password_set_ctrl #(
    .NUM_DIGITS(6), .TIMEOUT_CYCLES(10), .LOCK_CYCLES(20), .RESET_PASSWORD(24'h135790)
  ) u_dut_b (
    .clk(clk), .rst(rst), .set_req(set_req), .cancel(cancel),
    .digit(digit), .digit_valid(digit_valid),
    .password(password_b), .busy(busy_b), .done(done_b), .err(err_b),
    .err_code(err_code_b), .locked(locked_b), .digit_cnt(digit_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_set();
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic enter_pw(input logic [23:0] pw, input int n);
    for (int i = 0; i < n; i++) key(pw[(n-1-i)*4 +: 4]);
  endtask

  task automatic push_ev(input logic is_err, input logic [2:0] code, input logic [23:0] pw,
                         input int due);
    ev_t e;
    e.is_err = is_err;
    e.code   = code;
    e.pw     = pw;
    e.due    = 32'(due);
    exp_q.push_back(e);
  endtask

  // Every done/err pulse on the monitored DUT must match the oldest expected event.
  always @(negedge clk) begin
    logic        m_done, m_err;
    logic [2:0]  m_code;
    logic [23:0] m_pw;
    ev_t         e;
    m_done = mon_sel ? done_b : done_a;
    m_err  = mon_sel ? err_b  : err_a;
    m_code = mon_sel ? err_code_b : err_code_a;
    m_pw   = mon_sel ? password_b : 24'(password_a);
    if (!rst && (m_done || m_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, m_done, m_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_is_err", 32'(m_err), 32'(e.is_err));
        check("event_cycle", 32'(cyc), e.due);
        check("event_password", 32'(m_pw), 32'(e.pw));
        if (e.is_err) check("err_code", 32'(m_code), 32'(e.code));
      end
    end
  end

  initial begin
    int lock_start;
    int guard;
    rst = 1'b1; set_req = 1'b0; cancel = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset_password_a", 32'(password_a), 32'h0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_locked_a", 32'(locked_a), 32'd0);
    check("reset_err_code_a", 32'(err_code_a), 32'd0);
    check("reset_digit_cnt_a", 32'(digit_cnt_a), 32'd0);
    check("reset_password_b", 32'(password_b), 32'h135790);

    // Full change from reset password 0000 to 1234.
    pulse_set();
    check("busy_after_set", 32'(busy_a), 32'd1);
    key(4'd0); key(4'd0);
    check("digit_cnt_mid", 32'(digit_cnt_a), 32'd2);
    key(4'd0); key(4'd0);
    check("digit_cnt_chk", 32'(digit_cnt_a), 32'd0);
    tick();
    enter_pw(24'h1234, 4); tick();
    enter_pw(24'h1234, 4);
    push_ev(1'b0, 3'd0, 24'h1234, cyc + 1);
    tick(); tick();
    check("commit_password", 32'(password_a), 32'h1234);
    check("busy_after_commit", 32'(busy_a), 32'd0);

    // Three wrong old passwords lead to lockout.
    for (int f = 0; f < 3; f++) begin
      pulse_set();
      enter_pw(24'h9999, 4);
      push_ev(1'b1, 3'd1, 24'h1234, cyc + 1);
      tick();
      if (f < 2) begin
        check("not_locked_yet", 32'(locked_a), 32'd0);
        tick();
      end
    end
    check("locked_after_3", 32'(locked_a), 32'd1);
    check("password_kept_wrong_old", 32'(password_a), 32'h1234);
    lock_start = cyc;
    push_ev(1'b1, 3'd5, 24'h1234, cyc + 1);
    pulse_set();
    check("busy_while_locked", 32'(busy_a), 32'd0);
    guard = 0;
    while (locked_a && guard < 6000) begin
      tick();
      guard++;
    end
    check("lock_duration", 32'(cyc - lock_start), 32'd5000);

    // Correct old, mismatched confirm.
    pulse_set();
    enter_pw(24'h1234, 4); tick();
    enter_pw(24'h5678, 4); tick();
    enter_pw(24'h5679, 4);
    push_ev(1'b1, 3'd2, 24'h1234, cyc + 1);
    tick(); tick();
    check("password_kept_confirm", 32'(password_a), 32'h1234);

    // Out-of-range digit.
    pulse_set();
    key(4'd1);
    push_ev(1'b1, 3'd4, 24'h1234, cyc + 1);
    key(4'hC);
    check("busy_after_bad", 32'(busy_a), 32'd0);

    // Cancel beats a simultaneous digit; cancel in IDLE is ignored.
    pulse_set();
    key(4'd1);
    cancel = 1'b1; digit_valid = 1'b1; digit = 4'd2;
    push_ev(1'b1, 3'd6, 24'h1234, cyc + 1);
    tick();
    cancel = 1'b0; digit_valid = 1'b0;
    check("cnt_after_cancel", 32'(digit_cnt_a), 32'd0);
    cancel = 1'b1; tick(); cancel = 1'b0; tick();
    check("busy_idle_cancel", 32'(busy_a), 32'd0);
    check("pending_phase1", 32'(exp_q.size()), 32'd0);

    // Scaled build: 6 digits, 10-cycle timeout.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    mon_sel = 1'b1;
    pulse_set();
    key(4'd1); key(4'd2);
    push_ev(1'b1, 3'd3, 24'h135790, cyc + 10);
    for (int i = 0; i < 12; i++) tick();
    check("busy_after_timeout", 32'(busy_b), 32'd0);

    pulse_set();
    enter_pw(24'h135790, 6); tick();
    enter_pw(24'h987654, 6); tick();
    enter_pw(24'h987654, 6);
    push_ev(1'b0, 3'd0, 24'h987654, cyc + 1);
    tick(); tick();
    check("commit_password_b", 32'(password_b), 32'h987654);

    pulse_set();
    enter_pw(24'h987654, 6); tick();
    enter_pw(24'h111111, 6); tick();
    key(4'd2); key(4'd3);
    check("busy_mid_confirm", 32'(busy_b), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_password_b", 32'(password_b), 32'h135790);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_digit_cnt_b", 32'(digit_cnt_b), 32'd0);
    check("locked_b", 32'(locked_b), 32'd0);
    tick();
    check("pending_final", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
